dsdmnist_dotprod_engine: RTL

//  Parametrised pipelined signed dot-product engine: N_OPS-element int8 multiply, 3:1 adder tree,

---
 rtl/dsdmnist_dotprod_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dsdmnist_dotprod_engine.sv
// rtl/dsdmnist_dotprod_engine.sv - pipelined signed int8 dot-product engine with framed saturating accumulator
`timescale 1ns/1ps
module dsdmnist_dotprod_engine #(
  parameter int N_OPS      = 262,
  parameter int OPW        = 8,
  parameter int ACCW       = 32,
  parameter int NUM_OF_DSP = 218,
  parameter int SATURATE   = 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_VALID,
  input  logic                   i_FIRST,
  input  logic                   i_LAST,
  input  logic [N_OPS*OPW-1:0]   i_OPSET0,
  input  logic [N_OPS*OPW-1:0]   i_OPSET1,
  output logic                   o_VALID,
  output logic [ACCW-1:0]        o_ACC_OUT,
  output logic                   o_OVF
);

  function automatic int tree_stages();
    int n;
    int s;
    n = (N_OPS + 1) / 2;
    s = 0;
    while (n > 3) begin
      n = (n + 2) / 3;
      s++;
    end
    return s;
  endfunction

  function automatic int terms_at(input int k);
    int n;
    n = (N_OPS + 1) / 2;
    for (int i = 0; i < k; i++) n = (n + 2) / 3;
    return n;
  endfunction

  localparam int N1   = (N_OPS + 1) / 2;
  localparam int S    = tree_stages();
  localparam int NF   = terms_at(S);
  localparam int PW   = 2 * OPW;
  localparam int TW   = PW + 1 + 2 * S;
  localparam int SW   = ACCW + 1;
  localparam int TAGN = S + 2;

  logic signed [PW-1:0] prod_d [N_OPS];
  logic signed [PW-1:0] prod_q [N_OPS];
  logic signed [TW-1:0] lvl_d [S+1][N1];
  logic signed [TW-1:0] lvl_q [S+1][N1];

  logic [TAGN-1:0] vld_d, vld_q, fst_d, fst_q, lst_d, lst_q;
  logic signed [ACCW-1:0] acc_d, acc_q;
  logic ovf_d, ovf_q, out_vld_d, out_vld_q;

  logic signed [SW-1:0] beat_sum, base, sum_full;
  logic ovf_now;

  // Products beyond NUM_OF_DSP are steered to fabric logic.
  for (genvar g = 0; g < N_OPS; g++) begin : g_prod
    if (g < NUM_OF_DSP) begin : g_dsp
      (* use_dsp = "yes" *) logic signed [PW-1:0] p;
      assign p = PW'($signed(i_OPSET0[g*OPW +: OPW])) * PW'($signed(i_OPSET1[g*OPW +: OPW]));
      assign prod_d[g] = p;
    end else begin : g_lut
      (* use_dsp = "no" *) logic signed [PW-1:0] p;
      assign p = PW'($signed(i_OPSET0[g*OPW +: OPW])) * PW'($signed(i_OPSET1[g*OPW +: OPW]));
      assign prod_d[g] = p;
    end
  end

  always_comb begin
    int n_prev;
    int n_cur;
    for (int k = 0; k <= S; k++)
      for (int j = 0; j < N1; j++) lvl_d[k][j] = '0;
    for (int j = 0; j < N1; j++) begin
      if (2 * j + 1 < N_OPS) lvl_d[0][j] = TW'(prod_q[2*j]) + TW'(prod_q[2*j+1]);
      else                   lvl_d[0][j] = TW'(prod_q[2*j]);
    end
    // 3:1 reduction; groups past the previous level's term count are zero-padded.
    n_prev = N1;
    for (int k = 1; k <= S; k++) begin
      n_cur = (n_prev + 2) / 3;
      for (int j = 0; j < N1; j++)
        if (j < n_cur)
          for (int m = 0; m < 3; m++)
            if (3 * j + m < n_prev) lvl_d[k][j] = lvl_d[k][j] + lvl_q[k-1][3*j+m];
      n_prev = n_cur;
    end
  end

  always_comb begin
    vld_d = {vld_q[TAGN-2:0], i_VALID};
    fst_d = {fst_q[TAGN-2:0], i_VALID & i_FIRST};
    lst_d = {lst_q[TAGN-2:0], i_VALID & i_LAST};

    beat_sum = '0;
    for (int j = 0; j < NF; j++) beat_sum = beat_sum + SW'(lvl_q[S][j]);
    base     = fst_q[TAGN-1] ? '0 : SW'(acc_q);
    sum_full = base + beat_sum;
    ovf_now  = sum_full[SW-1] ^ sum_full[SW-2];

    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_vld_d = vld_q[TAGN-1] & lst_q[TAGN-1];
    if (vld_q[TAGN-1]) begin
      acc_d = sum_full[ACCW-1:0];
      if (ovf_now && SATURATE != 0)
        acc_d = sum_full[SW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      ovf_d = ovf_now | (ovf_q & ~fst_q[TAGN-1]);
    end
  end

  always_ff @(posedge i_CLK) begin
    prod_q <= prod_d;
    lvl_q  <= lvl_d;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      vld_q     <= '0;
      fst_q     <= '0;
      lst_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      fst_q     <= fst_d;
      lst_q     <= lst_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign o_VALID   = out_vld_q;
  assign o_ACC_OUT = acc_q;
  assign o_OVF     = ovf_q;

endmodule
